// File: rtl/itlb_refill_walker.sv
// itlb_refill_walker: scans the shared TLB array one entry per cycle on an
// instruction-side buffer miss and publishes a stable found/pfn/c/d/v result
// for the buffer stage. Any TLB buffer flush aborts the walk and clears the
// result.
// Optional build macro ITLB_WALK_LAST_HIT_EN: each walk starts at the index
// of the most recent successful match instead of index 0.
module itlb_refill_walker #(
  parameter int TLBNUM = 16,
  parameter int IDXW   = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            miss_req,
  input  logic [31:12]    miss_vpn,
  input  logic [7:0]      cur_asid,
  input  logic            TLB_Buffer_Flush,
  output logic [IDXW-1:0] r_index,
  input  logic [18:0]     r_vpn2,
  input  logic [7:0]      r_asid,
  input  logic            r_g,
  input  logic [19:0]     r_pfn0,
  input  logic [2:0]      r_c0,
  input  logic            r_d0,
  input  logic            r_v0,
  input  logic [19:0]     r_pfn1,
  input  logic [2:0]      r_c1,
  input  logic            r_d1,
  input  logic            r_v1,
  output logic            ITLB_found,
  output logic [19:0]     ITLB_pfn0,
  output logic [2:0]      ITLB_c0,
  output logic            ITLB_d0,
  output logic            ITLB_v0,
  output logic [19:0]     ITLB_pfn1,
  output logic [2:0]      ITLB_c1,
  output logic            ITLB_d1,
  output logic            ITLB_v1,
  output logic [18:0]     res_vpn2,
  output logic            res_valid,
  output logic            walk_busy,
  output logic            walk_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [IDXW-1:0] LAST_CNT = IDXW'(TLBNUM - 1);
  localparam logic [IDXW-1:0] ONE_IDX  = IDXW'(1);

  state_t          state_r;
  state_t          next_state_s;
  logic [IDXW-1:0] idx_r;
  logic [IDXW-1:0] cnt_r;
  logic [18:0]     vpn2_r;
  logic [7:0]      asid_r;
  logic [IDXW-1:0] start_idx_s;
  logic            accept_s;
  logic            hit_s;
  logic            last_s;
  logic            unused_vpn_lsb_s;

  // Bit 12 selects the even/odd page inside a pair; the walk only needs VPN2.
  assign unused_vpn_lsb_s = miss_vpn[12];

  // A new walk is needed only if the published result is for another page.
  assign accept_s = (state_r == ST_IDLE) && miss_req && !TLB_Buffer_Flush &&
                    (!res_valid || (miss_vpn[31:13] != res_vpn2));
  assign hit_s    = (state_r == ST_SCAN) && (r_vpn2 == vpn2_r) &&
                    (r_g || (r_asid == asid_r));
  assign last_s   = (state_r == ST_SCAN) && (cnt_r == LAST_CNT);

`ifdef ITLB_WALK_LAST_HIT_EN
  logic [IDXW-1:0] last_hit_r;

  // Remember where the last successful match was; survives flushes.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_hit_r <= {IDXW{1'b0}};
    end else if (!TLB_Buffer_Flush && hit_s) begin
      last_hit_r <= idx_r;
    end else begin
      last_hit_r <= last_hit_r;
    end
  end

  assign start_idx_s = last_hit_r;
`else
  assign start_idx_s = {IDXW{1'b0}};
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; a flush always returns to IDLE.
  always_comb begin
    next_state_s = state_r;
    if (TLB_Buffer_Flush) begin
      next_state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            next_state_s = ST_SCAN;
          end else begin
            next_state_s = ST_IDLE;
          end
        end
        ST_SCAN: begin
          if (hit_s || last_s) begin
            next_state_s = ST_DONE;
          end else begin
            next_state_s = ST_SCAN;
          end
        end
        ST_DONE: next_state_s = ST_IDLE;
        default: next_state_s = ST_IDLE;
      endcase
    end
  end

  // State-decoded outputs: array read index and busy flag.
  always_comb begin
    r_index   = {IDXW{1'b0}};
    walk_busy = 1'b0;
    if (state_r == ST_SCAN) begin
      r_index   = idx_r;
      walk_busy = 1'b1;
    end else if (state_r == ST_DONE) begin
      r_index   = {IDXW{1'b0}};
      walk_busy = 1'b1;
    end else begin
      r_index   = {IDXW{1'b0}};
      walk_busy = 1'b0;
    end
  end

  // Walk pointers, latched request and published result registers.
  always_ff @(posedge clk) begin
    if (reset || TLB_Buffer_Flush) begin
      idx_r      <= {IDXW{1'b0}};
      cnt_r      <= {IDXW{1'b0}};
      ITLB_found <= 1'b0;
      ITLB_pfn0  <= 20'd0;
      ITLB_c0    <= 3'd0;
      ITLB_d0    <= 1'b0;
      ITLB_v0    <= 1'b0;
      ITLB_pfn1  <= 20'd0;
      ITLB_c1    <= 3'd0;
      ITLB_d1    <= 1'b0;
      ITLB_v1    <= 1'b0;
      res_vpn2   <= 19'd0;
      res_valid  <= 1'b0;
      walk_done  <= 1'b0;
      if (reset) begin
        vpn2_r <= 19'd0;
        asid_r <= 8'd0;
      end else begin
        vpn2_r <= vpn2_r;
        asid_r <= asid_r;
      end
    end else begin
      walk_done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            vpn2_r <= miss_vpn[31:13];
            asid_r <= cur_asid;
            idx_r  <= start_idx_s;
            cnt_r  <= {IDXW{1'b0}};
          end
        end
        ST_SCAN: begin
          if (hit_s) begin
            ITLB_found <= 1'b1;
            ITLB_pfn0  <= r_pfn0;
            ITLB_c0    <= r_c0;
            ITLB_d0    <= r_d0;
            ITLB_v0    <= r_v0;
            ITLB_pfn1  <= r_pfn1;
            ITLB_c1    <= r_c1;
            ITLB_d1    <= r_d1;
            ITLB_v1    <= r_v1;
            res_vpn2   <= vpn2_r;
            res_valid  <= 1'b1;
            walk_done  <= 1'b1;
          end else if (last_s) begin
            ITLB_found <= 1'b0;
            ITLB_pfn0  <= 20'd0;
            ITLB_c0    <= 3'd0;
            ITLB_d0    <= 1'b0;
            ITLB_v0    <= 1'b0;
            ITLB_pfn1  <= 20'd0;
            ITLB_c1    <= 3'd0;
            ITLB_d1    <= 1'b0;
            ITLB_v1    <= 1'b0;
            res_vpn2   <= vpn2_r;
            res_valid  <= 1'b1;
            walk_done  <= 1'b1;
          end else begin
            idx_r <= idx_r + ONE_IDX;
            cnt_r <= cnt_r + ONE_IDX;
          end
        end
        default: begin
          idx_r <= idx_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_itlb_refill_walker.sv
// Directed bench for itlb_refill_walker with a per-cycle reference model.
// The model resolves each walk at accept time by searching the TLB array
// image, then counts off the scan latency before publishing.
`timescale 1ns/1ps
module tb_itlb_refill_walker;
  localparam int TLBNUM = 16;
  localparam int IDXW   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, miss_req, TLB_Buffer_Flush;
  logic [31:12]    miss_vpn;
  logic [7:0]      cur_asid;
  logic [IDXW-1:0] r_index;
  logic [18:0]     r_vpn2;
  logic [7:0]      r_asid;
  logic            r_g, r_d0, r_v0, r_d1, r_v1;
  logic [19:0]     r_pfn0, r_pfn1;
  logic [2:0]      r_c0, r_c1;
  logic            ITLB_found, ITLB_d0, ITLB_v0, ITLB_d1, ITLB_v1;
  logic [19:0]     ITLB_pfn0, ITLB_pfn1;
  logic [2:0]      ITLB_c0, ITLB_c1;
  logic [18:0]     res_vpn2;
  logic            res_valid, walk_busy, walk_done;

  // TLB array image
  logic [18:0] t_vpn2 [TLBNUM];
  logic [7:0]  t_asid [TLBNUM];
  logic        t_g    [TLBNUM];
  logic [19:0] t_pfn0 [TLBNUM];
  logic [19:0] t_pfn1 [TLBNUM];
  logic [2:0]  t_c0   [TLBNUM];
  logic [2:0]  t_c1   [TLBNUM];
  logic        t_d0   [TLBNUM];
  logic        t_v0   [TLBNUM];
  logic        t_d1   [TLBNUM];
  logic        t_v1   [TLBNUM];

  assign r_vpn2 = t_vpn2[r_index];
  assign r_asid = t_asid[r_index];
  assign r_g    = t_g[r_index];
  assign r_pfn0 = t_pfn0[r_index];
  assign r_pfn1 = t_pfn1[r_index];
  assign r_c0   = t_c0[r_index];
  assign r_c1   = t_c1[r_index];
  assign r_d0   = t_d0[r_index];
  assign r_v0   = t_v0[r_index];
  assign r_d1   = t_d1[r_index];
  assign r_v1   = t_v1[r_index];

  itlb_refill_walker #(.TLBNUM(TLBNUM), .IDXW(IDXW)) dut (
    .clk(clk), .reset(reset), .miss_req(miss_req), .miss_vpn(miss_vpn),
    .cur_asid(cur_asid), .TLB_Buffer_Flush(TLB_Buffer_Flush),
    .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
    .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
    .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1),
    .ITLB_found(ITLB_found), .ITLB_pfn0(ITLB_pfn0), .ITLB_c0(ITLB_c0),
    .ITLB_d0(ITLB_d0), .ITLB_v0(ITLB_v0), .ITLB_pfn1(ITLB_pfn1),
    .ITLB_c1(ITLB_c1), .ITLB_d1(ITLB_d1), .ITLB_v1(ITLB_v1),
    .res_vpn2(res_vpn2), .res_valid(res_valid), .walk_busy(walk_busy),
    .walk_done(walk_done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_phase;     // 0 idle, 1 scanning, 2 result just published
  int          m_pos, m_left, m_start, m_hit_e, m_last_hit, m_e;
  bit          m_hit;
  logic [18:0] m_vpn2, m_res_vpn2;
  logic        m_found, m_res_valid, m_done;
  logic [19:0] m_pfn0, m_pfn1;
  logic [2:0]  m_c0, m_c1;
  logic        m_d0, m_v0, m_d1, m_v1;

  task automatic m_clear_res();
    m_found = 1'b0; m_pfn0 = 20'd0; m_pfn1 = 20'd0; m_c0 = 3'd0; m_c1 = 3'd0;
    m_d0 = 1'b0; m_v0 = 1'b0; m_d1 = 1'b0; m_v1 = 1'b0;
    m_res_vpn2 = 19'd0; m_res_valid = 1'b0; m_done = 1'b0;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_clear_res();
      m_phase = 0; m_pos = 0; m_start = 0; m_last_hit = 0;
    end else if (TLB_Buffer_Flush) begin
      m_clear_res();
      m_phase = 0; m_pos = 0; m_start = 0;
    end else begin
      m_done = 1'b0;
      case (m_phase)
        0: begin
          if (miss_req && (!m_res_valid || miss_vpn[31:13] != m_res_vpn2)) begin
            m_vpn2 = miss_vpn[31:13];
`ifdef ITLB_WALK_LAST_HIT_EN
            m_start = m_last_hit;
`else
            m_start = 0;
`endif
            m_hit = 1'b0; m_left = TLBNUM; m_hit_e = 0;
            for (int k = 0; k < TLBNUM; k++) begin
              m_e = (m_start + k) % TLBNUM;
              if (!m_hit && t_vpn2[m_e] == m_vpn2 && (t_g[m_e] || t_asid[m_e] == cur_asid)) begin
                m_hit = 1'b1; m_hit_e = m_e; m_left = k + 1;
              end
            end
            m_pos = 0; m_phase = 1;
          end
        end
        1: begin
          if (m_pos == m_left - 1) begin
            m_clear_res();
            if (m_hit) begin
              m_found = 1'b1;
              m_pfn0 = t_pfn0[m_hit_e]; m_pfn1 = t_pfn1[m_hit_e];
              m_c0 = t_c0[m_hit_e]; m_c1 = t_c1[m_hit_e];
              m_d0 = t_d0[m_hit_e]; m_v0 = t_v0[m_hit_e];
              m_d1 = t_d1[m_hit_e]; m_v1 = t_v1[m_hit_e];
              m_last_hit = m_hit_e;
            end
            m_res_vpn2 = m_vpn2; m_res_valid = 1'b1; m_done = 1'b1;
            m_phase = 2; m_start = 0; m_pos = 0;
          end else begin
            m_pos++;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  // Compare DUT against the model every cycle, mid-period.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("walk_busy", {31'd0, walk_busy}, (m_phase != 0) ? 32'd1 : 32'd0);
      chk("walk_done", {31'd0, walk_done}, {31'd0, m_done});
      chk("res_valid", {31'd0, res_valid}, {31'd0, m_res_valid});
      chk("found", {31'd0, ITLB_found}, {31'd0, m_found});
      chk("pfn0", {12'd0, ITLB_pfn0}, {12'd0, m_pfn0});
      chk("pfn1", {12'd0, ITLB_pfn1}, {12'd0, m_pfn1});
      chk("cdv", {22'd0, ITLB_c0, ITLB_d0, ITLB_v0, ITLB_c1, ITLB_d1, ITLB_v1},
                 {22'd0, m_c0, m_d0, m_v0, m_c1, m_d1, m_v1});
      chk("res_vpn2", {13'd0, res_vpn2}, {13'd0, m_res_vpn2});
      chk("r_index", {28'd0, r_index},
          (m_phase == 1) ? 32'((m_start + m_pos) % TLBNUM) : 32'd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic fill_tlb();
    for (int i = 0; i < TLBNUM; i++) begin
      t_vpn2[i] = 19'h40000 | 19'(i);
      t_asid[i] = 8'hFF;
      t_g[i]    = 1'b0;
      t_pfn0[i] = 20'h10000 + 20'(i);
      t_pfn1[i] = 20'h20000 + 20'(i);
      t_c0[i]   = 3'(i);
      t_c1[i]   = ~3'(i);
      t_d0[i]   = i[0];
      t_d1[i]   = ~i[0];
      t_v0[i]   = 1'b1;
      t_v1[i]   = i[1];
    end
  endtask

  task automatic set_entry(input int e, input logic [18:0] vpn2, input logic [7:0] asid,
                           input logic g, input logic [19:0] p0, input logic [19:0] p1);
    t_vpn2[e] = vpn2; t_asid[e] = asid; t_g[e] = g; t_pfn0[e] = p0; t_pfn1[e] = p1;
  endtask

  task automatic do_reset();
    reset = 1'b1; miss_req = 1'b0; TLB_Buffer_Flush = 1'b0;
    fill_tlb();
    step(); step();
    reset = 1'b0;
  endtask

  // Counts cycles from the request cycle (cycle 0) to the walk_done cycle.
  task automatic wait_done(output int cyc);
    bit seen;
    seen = 1'b0; cyc = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (walk_done === 1'b1) seen = 1'b1;
    end
    chk("walk_done_seen", {31'd0, seen}, 32'd1);
  endtask

  int cyc;
  int ents[3] = '{0, 7, 15};

  initial begin
    reset = 1'b1; miss_req = 1'b0; miss_vpn = 20'd0; cur_asid = 8'd0;
    TLB_Buffer_Flush = 1'b0;
    do_reset();
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_busy", {31'd0, walk_busy}, 32'd0);
    chk("reset_res_valid", {31'd0, res_valid}, 32'd0);
    chk("reset_found", {31'd0, ITLB_found}, 32'd0);
    step();

    // Hit at entry 5, then hold-off on same VPN, then a full miss
    do_reset();
    set_entry(5, 19'h00200, 8'h01, 1'b0, 20'hABCDE, 20'h12345);
    cur_asid = 8'h01; miss_vpn = 20'h00400; miss_req = 1'b1;
    wait_done(cyc);
    chk("t1_latency", cyc, 32'd7);
    chk("t1_found", {31'd0, ITLB_found}, 32'd1);
    chk("t1_pfn0", {12'd0, ITLB_pfn0}, 32'hABCDE);
    chk("t1_pfn1", {12'd0, ITLB_pfn1}, 32'h12345);
    chk("t1_res_vpn2", {13'd0, res_vpn2}, 32'h00200);
    step(); step();
    chk("t2_no_rewalk", {31'd0, walk_busy}, 32'd0);
    miss_vpn = 20'h00800;
    wait_done(cyc);
    chk("t3_latency", cyc, 32'd17);
    chk("t3_found", {31'd0, ITLB_found}, 32'd0);
    chk("t3_pfn0", {12'd0, ITLB_pfn0}, 32'd0);
    chk("t3_v0", {31'd0, ITLB_v0}, 32'd0);
    chk("t3_res_valid", {31'd0, res_valid}, 32'd1);
    chk("t3_res_vpn2", {13'd0, res_vpn2}, 32'h00400);
    miss_req = 1'b0; step();

    // ASID mismatch at entry 3, global match at entry 9
    do_reset();
    cur_asid = 8'h01;
    set_entry(3, 19'h00300, 8'h02, 1'b0, 20'h33333, 20'h3333F);
    set_entry(9, 19'h00300, 8'h05, 1'b1, 20'h99999, 20'h9999F);
    miss_vpn = 20'h00600; miss_req = 1'b1;
    wait_done(cyc);
    chk("t4_latency", cyc, 32'd11);
    chk("t4_pfn0", {12'd0, ITLB_pfn0}, 32'h99999);
    miss_req = 1'b0; step();

    // Flush in cycle 4, request held high -> restart
    do_reset();
    cur_asid = 8'h01;
    set_entry(5, 19'h00200, 8'h01, 1'b0, 20'hABCDE, 20'h12345);
    miss_vpn = 20'h00400; miss_req = 1'b1;
    step(); step(); step(); step();
    TLB_Buffer_Flush = 1'b1;
    step();
    TLB_Buffer_Flush = 1'b0;
    chk("t5_idle_after_flush", {31'd0, walk_busy}, 32'd0);
    chk("t5_res_valid", {31'd0, res_valid}, 32'd0);
    chk("t5_no_done", {31'd0, walk_done}, 32'd0);
    step();
    chk("t5_restart", {31'd0, walk_busy}, 32'd1);
    wait_done(cyc);
    chk("t5_latency", cyc, 32'd6);
    miss_req = 1'b0; step();

    // Flush in the same cycle as the match
    do_reset();
    cur_asid = 8'h01;
    set_entry(5, 19'h00200, 8'h01, 1'b0, 20'hABCDE, 20'h12345);
    miss_vpn = 20'h00400; miss_req = 1'b1;
    for (int i = 0; i < 6; i++) step();
    TLB_Buffer_Flush = 1'b1; miss_req = 1'b0;
    step();
    TLB_Buffer_Flush = 1'b0;
    chk("t5b_no_done", {31'd0, walk_done}, 32'd0);
    chk("t5b_res_valid", {31'd0, res_valid}, 32'd0);
    chk("t5b_found", {31'd0, ITLB_found}, 32'd0);
    step();

    // First, middle and last array positions
    for (int j = 0; j < 3; j++) begin
      do_reset();
      cur_asid = 8'h01;
      set_entry(ents[j], 19'h01000 + 19'(ents[j]), 8'h01, 1'b0,
                20'h50000 + 20'(ents[j]), 20'h60000 + 20'(ents[j]));
      miss_vpn = {19'h01000 + 19'(ents[j]), 1'b1}; miss_req = 1'b1;
      wait_done(cyc);
      chk("sweep_latency", cyc, 32'(ents[j] + 2));
      chk("sweep_pfn0", {12'd0, ITLB_pfn0}, 32'h50000 + 32'(ents[j]));
      miss_req = 1'b0; step();
    end

    // Hit at 14 then at 1: wrap-around when starting from the last hit
    do_reset();
    cur_asid = 8'h01;
    set_entry(14, 19'h00700, 8'h01, 1'b0, 20'hEEEEE, 20'hEEEEF);
    set_entry(1,  19'h00080, 8'h01, 1'b0, 20'h11111, 20'h1111F);
    miss_vpn = {19'h00700, 1'b0}; miss_req = 1'b1;
    wait_done(cyc);
    chk("t6_first_latency", cyc, 32'd16);
    step();
    miss_vpn = {19'h00080, 1'b0};
    wait_done(cyc);
`ifdef ITLB_WALK_LAST_HIT_EN
    chk("t6_wrap_latency", cyc, 32'd5);
`else
    chk("t6_wrap_latency", cyc, 32'd3);
`endif
    chk("t6_pfn0", {12'd0, ITLB_pfn0}, 32'h11111);
    miss_req = 1'b0; step(); step();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
